vending_machine_multi: RTL
==========================

Name: vending_machine_multi

Overview:
- Parametrised successor to the single-price vending controller.
- Accepts nickel, dime, quarter and dollar pulses, up to a capped credit, for NUM_ITEMS items with individual prices and stock counts.
- Returns change or refunds as a serial stream of coin pulses (quarters first, then dimes, then nickels).
- Sits between the coin/button front-end and the dispenser/coin-hopper drivers.
- All money values are in nickel units (1 = 5 cents).

Parameters:
NUM_ITEMS, 4, number of selectable items (1..8)
CREDIT_W, 8, width of credit register and prices
MAX_CREDIT, 100, credit cap in nickels ($5.00); must be < 2**CREDIT_W
ITEM_PRICES, {8'd15,8'd30,8'd25,8'd10}, packed NUM_ITEMS*CREDIT_W prices; item 0 in the LSBs
STOCK_W, 4, width of each per-item stock counter
INIT_STOCK, 5, stock loaded into every item at reset and on restock

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_nickel  input  1  coin pulse, value 1
i_dime  input  1  coin pulse, value 2
i_quarter  input  1  coin pulse, value 5
i_dollar  input  1  coin pulse, value 20
i_refund  input  1  refund request
i_select  input  NUM_ITEMS  one-hot item select
i_restock  input  1  reload all stock counters to INIT_STOCK
o_item  output  NUM_ITEMS  one-hot dispense pulse, 1 cycle
o_credit  output  CREDIT_W  current credit
o_coin_q  output  1  return one quarter this cycle
o_coin_d  output  1  return one dime this cycle
o_coin_n  output  1  return one nickel this cycle
o_busy  output  1  high while in VEND or CHANGE
o_msg_en  output  1  1-cycle message strobe
o_msg_code  output  2  0 none, 1 insufficient funds, 2 sold out, 3 coin rejected/invalid select
o_sold_out  output  NUM_ITEMS  per-item stock==0 flags (combinational from counters)

Behaviour:
- Inputs are synchronous; each asserted cycle counts as one event. The bench holds each input for exactly one clock.
- Reset (async assert, sync release) values:
  - state=IDLE; credit=0; all stock=INIT_STOCK.
  - o_item=0; coin outputs=0; o_msg_en=0; o_msg_code=0; o_busy=0.
- Reset mid-CHANGE aborts the payout immediately; the remaining credit is lost.
- States and transitions:
  - IDLE: accepts coins, refund, select and restock.
  - VEND: single cycle. o_item=selected one-hot; credit -= price; stock -= 1. Then go to CHANGE if credit>0, else IDLE.
  - CHANGE: one coin per cycle, greedy:
    - credit>=5: o_coin_q, credit-=5
    - else credit>=2: o_coin_d, credit-=2
    - else: o_coin_n, credit-=1
    - Go to IDLE on the cycle credit reaches 0.
- Coins in IDLE:
  - All asserted coins in a cycle are summed; credit updates on the next edge.
  - If credit+sum > MAX_CREDIT, the whole sum is rejected: credit unchanged, o_msg_en=1, code 3.
  - Any coin while o_busy=1 is rejected with code 3.
- Priority in IDLE, same cycle: refund > select > coins.
  - Coins coincident with refund or a valid select are rejected with code 3.
- Refund:
  - credit>0: go to CHANGE next edge.
  - credit=0: no action, no message.
- Select in IDLE:
  - Zero bits set: ignored.
  - More than one bit set: code 3, no vend.
  - Item stock=0: code 2, credit kept.
  - credit < price: code 1, credit kept.
  - Otherwise go to VEND next edge. o_item appears 1 cycle after the select cycle; the first change coin appears 2 cycles after.
- Messages:
  - o_msg_en is registered, high for exactly 1 cycle.
  - o_msg_code holds its value until the next message and is cleared by reset.
- Restock:
  - Honoured only in IDLE; ignored while busy.
  - Coincident with a select, the restock occurs and the select is evaluated against the pre-restock stock.
- Stock saturates at 0; it never decrements below 0.
- Width rule: coin sum and cap comparison are computed at CREDIT_W+1 bits to avoid overflow.

Test Plan:
- Exact payment: quarter, quarter, select item0 (price 10) -> o_item=0001 for 1 cycle, credit 0, no coin pulses, o_busy back low the following cycle.
- Change: quarter, quarter, dollar, quarter (credit 35), select item1 (price 25) -> o_item=0010, credit 10, then o_coin_q on 2 consecutive cycles, credit 0, state IDLE.
- Cap: 5 dollars (credit 100), then a 6th dollar -> rejected, msg code 3, credit stays 100. Then select item2 (price 30) -> o_item=0100, then 14 consecutive o_coin_q pulses.
- Refund mix: nickel, dime, quarter (credit 8), refund -> o_coin_q, o_coin_d, o_coin_n on 3 consecutive cycles, credit 0.
- Errors:
  - credit 10, select item1 -> code 1, credit 10.
  - select 0011 -> code 3.
  - Bench with INIT_STOCK=1: buy item0 twice -> second attempt gives code 2 and o_sold_out[0]=1; assert i_restock -> o_sold_out[0]=0.
- Reset mid-payout: assert i_rst_n low during a 14-quarter payout -> all outputs 0 immediately, credit 0, stock back to INIT_STOCK.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit up to a cap, per-item prices and stock,
// greedy serial change/refund payout (quarters, then dimes, then nickels).
`timescale 1ns/1ps

module vending_machine_multi #(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            CREDIT_W    = 8,
    parameter int                            MAX_CREDIT  = 100,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {8'd15, 8'd30, 8'd25, 8'd10},
    parameter int                            STOCK_W     = 4,
    parameter int                            INIT_STOCK  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_nickel,
    input  logic                 i_dime,
    input  logic                 i_quarter,
    input  logic                 i_dollar,
    input  logic                 i_refund,
    input  logic [NUM_ITEMS-1:0] i_select,
    input  logic                 i_restock,
    output logic [NUM_ITEMS-1:0] o_item,
    output logic [CREDIT_W-1:0]  o_credit,
    output logic                 o_coin_q,
    output logic                 o_coin_d,
    output logic                 o_coin_n,
    output logic                 o_busy,
    output logic                 o_msg_en,
    output logic [1:0]           o_msg_code,
    output logic [NUM_ITEMS-1:0] o_sold_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0]   NICKEL_VAL  = (CREDIT_W+1)'(32'd1);
    localparam logic [CREDIT_W:0]   DIME_VAL    = (CREDIT_W+1)'(32'd2);
    localparam logic [CREDIT_W:0]   QUARTER_VAL = (CREDIT_W+1)'(32'd5);
    localparam logic [CREDIT_W:0]   DOLLAR_VAL  = (CREDIT_W+1)'(32'd20);
    localparam logic [CREDIT_W:0]   CAP_VAL     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  STOCK_INIT  = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0]  STOCK_ONE   = STOCK_W'(32'd1);
    localparam logic [1:0]          MSG_FUNDS   = 2'd1;
    localparam logic [1:0]          MSG_SOLD    = 2'd2;
    localparam logic [1:0]          MSG_REJECT  = 2'd3;

    // Greedy coin choice for a remaining amount, returned as {quarter, dime, nickel}.
    function automatic logic [2:0] coin_sel(input logic [CREDIT_W-1:0] amount);
        logic [2:0] sel;
        if (amount >= CREDIT_W'(32'd5)) begin
            sel = 3'b100;
        end else if (amount >= CREDIT_W'(32'd2)) begin
            sel = 3'b010;
        end else if (amount != '0) begin
            sel = 3'b001;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] sel);
        logic [CREDIT_W-1:0] val;
        case (sel)
            3'b100:  val = CREDIT_W'(32'd5);
            3'b010:  val = CREDIT_W'(32'd2);
            3'b001:  val = CREDIT_W'(32'd1);
            default: val = '0;
        endcase
        return val;
    endfunction

    state_t               state_r;
    logic [CREDIT_W-1:0]  credit_r;
    logic [STOCK_W-1:0]   stock_r [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] item_r;
    logic                 coin_q_r;
    logic                 coin_d_r;
    logic                 coin_n_r;
    logic                 busy_r;
    logic                 msg_en_r;
    logic [1:0]           msg_code_r;

    logic [CREDIT_W:0]    coin_sum_s;
    logic [CREDIT_W:0]    credit_sum_s;
    logic                 any_coin_s;
    logic                 over_cap_s;
    logic                 sel_none_s;
    logic                 sel_one_hot_s;
    logic [CREDIT_W-1:0]  sel_price_s;
    logic [STOCK_W-1:0]   sel_stock_s;
    logic [CREDIT_W-1:0]  change_rem_s;
    logic [NUM_ITEMS-1:0] sold_out_s;

    // Coin summation and cap test, one bit wider than credit so nothing wraps.
    always_comb begin
        coin_sum_s   = (i_nickel  ? NICKEL_VAL  : '0)
                     + (i_dime    ? DIME_VAL    : '0)
                     + (i_quarter ? QUARTER_VAL : '0)
                     + (i_dollar  ? DOLLAR_VAL  : '0);
        credit_sum_s = {1'b0, credit_r} + coin_sum_s;
        any_coin_s   = i_nickel | i_dime | i_quarter | i_dollar;
        over_cap_s   = (credit_sum_s > CAP_VAL);
        change_rem_s = credit_r - coin_value(coin_sel(credit_r));
    end

    // Price/stock of the selected item, AND-OR muxed from the one-hot select.
    always_comb begin
        sel_none_s    = (i_select == '0);
        sel_one_hot_s = $onehot(i_select);
        sel_price_s   = '0;
        sel_stock_s   = '0;
        sold_out_s    = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sel_price_s   = sel_price_s | (ITEM_PRICES[i*CREDIT_W +: CREDIT_W] & {CREDIT_W{i_select[i]}});
            sel_stock_s   = sel_stock_s | (stock_r[i] & {STOCK_W{i_select[i]}});
            sold_out_s[i] = (stock_r[i] == '0);
        end
    end

    // Main controller FSM with registered outputs; strobes default low each cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            credit_r   <= '0;
            item_r     <= '0;
            coin_q_r   <= 1'b0;
            coin_d_r   <= 1'b0;
            coin_n_r   <= 1'b0;
            busy_r     <= 1'b0;
            msg_en_r   <= 1'b0;
            msg_code_r <= 2'd0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= STOCK_INIT;
            end
        end else begin
            item_r   <= '0;
            coin_q_r <= 1'b0;
            coin_d_r <= 1'b0;
            coin_n_r <= 1'b0;
            msg_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            stock_r[i] <= STOCK_INIT;
                        end
                    end
                    if (i_refund) begin
                        if (any_coin_s) begin
                            msg_en_r   <= 1'b1;
                            msg_code_r <= MSG_REJECT;
                        end
                        if (credit_r != '0) begin
                            state_r                        <= ST_CHANGE;
                            busy_r                         <= 1'b1;
                            {coin_q_r, coin_d_r, coin_n_r} <= coin_sel(credit_r);
                        end
                    end else if (!sel_none_s && sel_one_hot_s && sel_stock_s != '0
                                 && credit_r >= sel_price_s) begin
                        // Valid purchase: charge now so VEND already shows the remainder.
                        state_r  <= ST_VEND;
                        busy_r   <= 1'b1;
                        item_r   <= i_select;
                        credit_r <= credit_r - sel_price_s;
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            if (i_select[i]) begin
                                stock_r[i] <= (i_restock ? STOCK_INIT : stock_r[i]) - STOCK_ONE;
                            end
                        end
                        if (any_coin_s) begin
                            msg_en_r   <= 1'b1;
                            msg_code_r <= MSG_REJECT;
                        end
                    end else begin
                        // No vend this cycle: coins still count unless they break the cap.
                        if (any_coin_s && !over_cap_s) begin
                            credit_r <= credit_sum_s[CREDIT_W-1:0];
                        end
                        if (!sel_none_s) begin
                            msg_en_r <= 1'b1;
                            if (!sel_one_hot_s) begin
                                msg_code_r <= MSG_REJECT;
                            end else if (sel_stock_s == '0) begin
                                msg_code_r <= MSG_SOLD;
                            end else begin
                                msg_code_r <= MSG_FUNDS;
                            end
                        end else if (any_coin_s && over_cap_s) begin
                            msg_en_r   <= 1'b1;
                            msg_code_r <= MSG_REJECT;
                        end
                    end
                end
                ST_VEND: begin
                    if (any_coin_s) begin
                        msg_en_r   <= 1'b1;
                        msg_code_r <= MSG_REJECT;
                    end
                    if (credit_r != '0) begin
                        state_r                        <= ST_CHANGE;
                        busy_r                         <= 1'b1;
                        {coin_q_r, coin_d_r, coin_n_r} <= coin_sel(credit_r);
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    if (any_coin_s) begin
                        msg_en_r   <= 1'b1;
                        msg_code_r <= MSG_REJECT;
                    end
                    credit_r <= change_rem_s;
                    if (change_rem_s != '0) begin
                        state_r                        <= ST_CHANGE;
                        busy_r                         <= 1'b1;
                        {coin_q_r, coin_d_r, coin_n_r} <= coin_sel(change_rem_s);
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_item     = item_r;
    assign o_credit   = credit_r;
    assign o_coin_q   = coin_q_r;
    assign o_coin_d   = coin_d_r;
    assign o_coin_n   = coin_n_r;
    assign o_busy     = busy_r;
    assign o_msg_en   = msg_en_r;
    assign o_msg_code = msg_code_r;
    assign o_sold_out = sold_out_s;

endmodule
